// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by a shared oversampling tick.
// The line is synchronised, the start bit is confirmed at mid-bit, and each
// data/stop bit is sampled at its centre. Completed frames are reported with
// a one-cycle valid (good stop) or frame_err (bad stop) pulse.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TCNT_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          tcnt_reg, tcnt_next;
  logic [BW-1:0]          bcnt_reg, bcnt_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic                   ferr_reg, ferr_next;

  // Two-flop synchroniser chain; stage gi takes its input from sync_in[gi].
  logic [1:0] sync_reg;
  logic [1:0] sync_in;
  logic       rx_s;

  assign sync_in = {sync_reg[0], rx};
  assign rx_s    = sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      // Synchroniser stage; resets to the idle (high) line level.
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= 1'b1;
        else     sync_reg[gi] <= sync_in[gi];
      end
    end
  endgenerate

  // State, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tcnt_reg  <= '0;
      bcnt_reg  <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_next;
      bcnt_reg  <= bcnt_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Next-state logic; everything holds on cycles without a tick.
  always_comb begin
    state_next = state_reg;
    tcnt_next  = tcnt_reg;
    bcnt_next  = bcnt_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        tcnt_next = '0;
        bcnt_next = '0;
        if (tick && !rx_s) state_next = START;
      end

      START: begin
        if (tick) begin
          if (tcnt_reg == TCNT_MID) begin
            // Mid start bit: a high line here was only a glitch.
            tcnt_next  = '0;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            tcnt_next = tcnt_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tcnt_reg == TCNT_LAST) begin
            tcnt_next  = '0;
            // Right shift: the first (LSB) bit ends up in bit 0.
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bcnt_reg == BCNT_LAST) begin
              bcnt_next  = '0;
              state_next = STOP;
            end else begin
              bcnt_next = bcnt_reg + 1'b1;
            end
          end else begin
            tcnt_next = tcnt_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tcnt_reg == TCNT_LAST) begin
            tcnt_next = '0;
            data_next = shift_reg;
            if (rx_s) begin
              valid_next = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_next  = 1'b1;
              state_next = WAIT_IDLE;
            end
          end else begin
            tcnt_next = tcnt_reg + 1'b1;
          end
        end
      end

      WAIT_IDLE: begin
        // Hold off until the line is released so a break is not a new start.
        if (tick && rx_s) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign data_out  = data_reg;
  assign valid     = valid_reg;
  assign frame_err = ferr_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialised by the bench at
// 16 ticks/bit with a tick every 4 clocks (64 clocks per bit).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Observed pulse bookkeeping, written only by the monitor.
  int         valid_cnt   = 0;
  int         ferr_cnt    = 0;
  int         overlap_cnt = 0;
  int         long_cnt    = 0;
  logic [7:0] got_q[$];

  localparam int BIT_CLKS = 64;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Tick: one clock high out of every four.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Pulse monitor sampled on the falling edge.
  initial begin
    logic prev_v;
    logic prev_f;
    prev_v = 1'b0;
    prev_f = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        valid_cnt++;
        got_q.push_back(data_out);
        $display("rx byte %02h (valid) at %0t", data_out, $time);
      end
      if (frame_err === 1'b1) begin
        ferr_cnt++;
        $display("rx byte %02h (frame_err) at %0t", data_out, $time);
      end
      if (valid === 1'b1 && frame_err === 1'b1) overlap_cnt++;
      if ((valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_f)) long_cnt++;
      prev_v = (valid === 1'b1);
      prev_f = (frame_err === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  initial begin
    int v0;
    int f0;
    int q0;
    rx  = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset data_out", {24'd0, data_out}, 32'h00);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Basic byte.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    repeat (8) @(negedge clk);
    check("basic data", {24'd0, data_out}, 32'hA5);
    check("basic valid count", valid_cnt - v0, 32'd1);
    check("basic no frame_err", ferr_cnt - f0, 32'd0);
    check("basic busy low", {31'd0, busy}, 32'd0);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    q0 = got_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (8) @(negedge clk);
    check("b2b count", got_q.size() - q0, 32'd2);
    if (got_q.size() >= q0 + 2) begin
      check("b2b first", {24'd0, got_q[q0]}, 32'h00);
      check("b2b second", {24'd0, got_q[q0+1]}, 32'hFF);
    end

    // Start glitch of 3 ticks.
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (4 * 32) @(negedge clk);
    check("glitch no valid", valid_cnt - v0, 32'd0);
    check("glitch no frame_err", ferr_cnt - f0, 32'd0);
    check("glitch data held", {24'd0, data_out}, 32'hFF);
    check("glitch busy low", {31'd0, busy}, 32'd0);

    // Framing error followed by a 40-tick break.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (4 * 40) @(negedge clk);
    check("ferr count", ferr_cnt - f0, 32'd1);
    check("ferr no valid", valid_cnt - v0, 32'd0);
    check("ferr data", {24'd0, data_out}, 32'h3C);
    check("break busy held", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (4 * 16) @(negedge clk);
    check("break released busy", {31'd0, busy}, 32'd0);
    send_frame(8'h55, 1'b1);
    repeat (8) @(negedge clk);
    check("after break data", {24'd0, data_out}, 32'h55);
    check("after break valid", valid_cnt - v0, 32'd1);
    check("after break ferr", ferr_cnt - f0, 32'd1);

    // Reset during data bit 4 of 0xF0 (line is high from bit 4 on).
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst data_out", {24'd0, data_out}, 32'h00);
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst valid", {31'd0, valid}, 32'd0);
    check("mid rst frame_err", {31'd0, frame_err}, 32'd0);
    repeat (BIT_CLKS * 12) @(negedge clk);
    check("abort no valid", valid_cnt - v0, 32'd0);
    check("abort no frame_err", ferr_cnt - f0, 32'd0);
    send_frame(8'h81, 1'b1);
    repeat (8) @(negedge clk);
    check("post reset data", {24'd0, data_out}, 32'h81);
    check("post reset valid", valid_cnt - v0, 32'd1);

    // Stream of three frames back to back.
    q0 = got_q.size(); f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'h5A, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (8) @(negedge clk);
    check("stream count", got_q.size() - q0, 32'd3);
    if (got_q.size() >= q0 + 3) begin
      check("stream byte0", {24'd0, got_q[q0]}, 32'h00);
      check("stream byte1", {24'd0, got_q[q0+1]}, 32'h5A);
      check("stream byte2", {24'd0, got_q[q0+2]}, 32'hFF);
    end
    check("stream no ferr", ferr_cnt - f0, 32'd0);

    // Pulse shape over the whole run.
    check("pulse overlap", overlap_cnt, 32'd0);
    check("pulse width", long_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
